// File: rtl/cv32e40p_x_wb_pkg.sv
// Shared types and defaults for the X-interface writeback buffer.
package cv32e40p_x_wb_pkg;

    localparam int unsigned DefaultDepth          = 2;
    localparam int unsigned DefaultMaxOutstanding = 4;
    localparam int unsigned DefaultXlen           = 32;

    // One buffered accelerator response. The data field is sized for the
    // default XLEN; the top-level XLEN parameter must match it.
    typedef struct packed {
        logic [4:0]               rd;
        logic [2*DefaultXlen-1:0] data;
        logic                     dualwb;
        logic                     error;
    } wb_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StWbLo,
        StWbHi
    } wb_state_e;

    // Second register of a dual writeback; wraps x31 -> x0.
    function automatic logic [4:0] next_reg(input logic [4:0] rd);
        return rd + 5'd1;
    endfunction

endpackage

// File: rtl/cv32e40p_x_wb_fifo.sv
// Generic synchronous FIFO, Depth entries (power of two), no bypass.
module cv32e40p_x_wb_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AddrW:0]   wptr_q, wptr_d;
    logic [AddrW:0]   rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign data_o  = mem_q[rptr_q[AddrW-1:0]];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer advance on accepted push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer state; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; empty pointers mask stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AddrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/cv32e40p_x_wb_buffer.sv
// Buffers X-interface responses and drains them onto the shared register-file
// write port; tracks busy destination registers and outstanding offloads.
module cv32e40p_x_wb_buffer
    import cv32e40p_x_wb_pkg::*;
#(
    parameter int unsigned Depth          = DefaultDepth,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
    parameter int unsigned XLEN           = DefaultXlen
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   x_q_valid_i,
    input  logic                                   x_q_ready_i,
    input  logic                                   x_k_accept_i,
    input  logic                                   x_k_writeback_i,
    input  logic [4:0]                             x_q_rd_i,
    input  logic                                   x_p_valid_i,
    output logic                                   x_p_ready_o,
    input  logic [4:0]                             x_p_rd_i,
    input  logic [2*XLEN-1:0]                      x_p_data_i,
    input  logic                                   x_p_dualwb_i,
    input  logic                                   x_p_error_i,
    output logic                                   wb_req_o,
    input  logic                                   wb_gnt_i,
    output logic [4:0]                             wb_addr_o,
    output logic [XLEN-1:0]                        wb_data_o,
    output logic [31:0]                            rd_busy_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   issue_stall_o,
    output logic                                   err_valid_o,
    output logic [4:0]                             err_rd_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic      issue, push, pop, full, empty;
    wb_entry_t push_entry, head;
    wb_state_e state_q, state_d;
    logic [31:0]     busy_q, busy_d, set_mask, clr_mask;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      hi_rd;
    logic            do_err, do_lo, do_hi, lo_skip, hi_skip;

    assign issue = x_q_valid_i & x_q_ready_i & x_k_accept_i;

    // No bypass: a full FIFO stays not-ready even while popping.
    assign x_p_ready_o = ~full & ~rst_i;
    assign push        = x_p_valid_i & x_p_ready_o;

    assign push_entry = '{rd: x_p_rd_i, data: x_p_data_i, dualwb: x_p_dualwb_i,
                          error: x_p_error_i};

    cv32e40p_x_wb_fifo #(
        .Width ($bits(wb_entry_t)),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // IDLE evaluates the head in the same cycle, so a non-error head performs
    // its low beat immediately; WB_LO only exists to hold while ungranted.
    assign hi_rd   = next_reg(head.rd);
    assign do_err  = (state_q == StIdle) && !empty && head.error;
    assign do_lo   = ((state_q == StIdle) && !empty && !head.error) || (state_q == StWbLo);
    assign do_hi   = (state_q == StWbHi);
    assign lo_skip = (head.rd == 5'd0);
    assign hi_skip = (hi_rd == 5'd0);

    // Drain sequencing: write-port beats, error reporting, pop and busy clear.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        clr_mask    = '0;
        wb_req_o    = 1'b0;
        wb_addr_o   = '0;
        wb_data_o   = '0;
        err_valid_o = 1'b0;
        err_rd_o    = '0;
        if (do_err) begin
            err_valid_o = 1'b1;
            err_rd_o    = head.rd;
            pop         = 1'b1;
            clr_mask    = 32'd1 << head.rd;
            state_d     = StIdle;
        end else if (do_lo) begin
            if (!lo_skip) begin
                wb_req_o  = 1'b1;
                wb_addr_o = head.rd;
                wb_data_o = head.data[XLEN-1:0];
            end
            // x0 beats complete without a grant.
            if (lo_skip || wb_gnt_i) begin
                if (head.dualwb) begin
                    state_d = StWbHi;
                end else begin
                    pop      = 1'b1;
                    clr_mask = 32'd1 << head.rd;
                    state_d  = StIdle;
                end
            end else begin
                state_d = StWbLo;
            end
        end else if (do_hi) begin
            if (!hi_skip) begin
                wb_req_o  = 1'b1;
                wb_addr_o = hi_rd;
                wb_data_o = head.data[2*XLEN-1:XLEN];
            end
            if (hi_skip || wb_gnt_i) begin
                pop      = 1'b1;
                clr_mask = (32'd1 << head.rd) | (32'd1 << hi_rd);
                state_d  = StIdle;
            end
        end
    end

    // Scoreboard and retire counter next state; a same-cycle set beats a clear.
    always_comb begin
        set_mask = '0;
        if (issue && x_k_writeback_i && (x_q_rd_i != 5'd0)) set_mask = 32'd1 << x_q_rd_i;
        busy_d = (busy_q & ~clr_mask) | set_mask;
        cnt_d  = cnt_q + CntW'(issue) - CntW'(pop);
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_busy_o     = busy_q;
    assign outstanding_o = cnt_q;
    assign issue_stall_o = (cnt_q == CntW'(MaxOutstanding));

    // A stalled issue is legal only when a retire frees the slot that cycle.
    a_issue_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(issue && issue_stall_o && !pop));
    a_retire_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && (cnt_q == '0) && !issue));

endmodule

// File: tb/tb_cv32e40p_x_wb_buffer.sv
module tb_cv32e40p_x_wb_buffer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        x_q_valid_i, x_q_ready_i, x_k_accept_i, x_k_writeback_i;
    logic [4:0]  x_q_rd_i;
    logic        x_p_valid_i, x_p_ready_o;
    logic [4:0]  x_p_rd_i;
    logic [63:0] x_p_data_i;
    logic        x_p_dualwb_i, x_p_error_i;
    logic        wb_req_o, wb_gnt_i;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] rd_busy_o;
    logic [2:0]  outstanding_o;
    logic        issue_stall_o, err_valid_o;
    logic [4:0]  err_rd_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cv32e40p_x_wb_buffer dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .x_q_valid_i     (x_q_valid_i),
        .x_q_ready_i     (x_q_ready_i),
        .x_k_accept_i    (x_k_accept_i),
        .x_k_writeback_i (x_k_writeback_i),
        .x_q_rd_i        (x_q_rd_i),
        .x_p_valid_i     (x_p_valid_i),
        .x_p_ready_o     (x_p_ready_o),
        .x_p_rd_i        (x_p_rd_i),
        .x_p_data_i      (x_p_data_i),
        .x_p_dualwb_i    (x_p_dualwb_i),
        .x_p_error_i     (x_p_error_i),
        .wb_req_o        (wb_req_o),
        .wb_gnt_i        (wb_gnt_i),
        .wb_addr_o       (wb_addr_o),
        .wb_data_o       (wb_data_o),
        .rd_busy_o       (rd_busy_o),
        .outstanding_o   (outstanding_o),
        .issue_stall_o   (issue_stall_o),
        .err_valid_o     (err_valid_o),
        .err_rd_o        (err_rd_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic wb);
        x_q_valid_i = 1'b1; x_q_ready_i = 1'b1; x_k_accept_i = 1'b1;
        x_k_writeback_i = wb; x_q_rd_i = rd;
    endtask

    task automatic clr_issue();
        x_q_valid_i = 1'b0; x_q_ready_i = 1'b0; x_k_accept_i = 1'b0;
        x_k_writeback_i = 1'b0; x_q_rd_i = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic wb);
        set_issue(rd, wb);
        tick();
        clr_issue();
    endtask

    // Present a response, wait (bounded) for ready, complete one handshake.
    task automatic send_resp(input logic [4:0] rd, input logic [63:0] data,
                             input logic dual, input logic err);
        int n = 0;
        x_p_valid_i = 1'b1; x_p_rd_i = rd; x_p_data_i = data;
        x_p_dualwb_i = dual; x_p_error_i = err;
        while (!x_p_ready_o && n < 50) begin tick(); n++; end
        total++;
        if (x_p_ready_o !== 1'b1) begin
            bad++; $display("FAIL resp_handshake_timeout: ready=%0b want 1", x_p_ready_o);
        end
        tick();
        x_p_valid_i = 1'b0; x_p_dualwb_i = 1'b0; x_p_error_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        total++; if (x_p_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", x_p_ready_o); end
        total++; if (wb_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %0b want 0", wb_req_o); end
        total++; if (wb_addr_o !== 5'd0 || wb_data_o !== 32'd0) begin bad++; $display("FAIL rst_wb: addr=%0d data=%h want 0", wb_addr_o, wb_data_o); end
        total++; if (rd_busy_o !== 32'd0) begin bad++; $display("FAIL rst_busy: got %h want 0", rd_busy_o); end
        total++; if (outstanding_o !== 3'd0 || issue_stall_o !== 1'b0) begin bad++; $display("FAIL rst_cnt: cnt=%0d stall=%0b want 0", outstanding_o, issue_stall_o); end
        total++; if (err_valid_o !== 1'b0 || err_rd_o !== 5'd0) begin bad++; $display("FAIL rst_err: v=%0b rd=%0d want 0", err_valid_o, err_rd_o); end
        rst_i = 1'b0;
        tick();
        total++; if (x_p_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %0b want 1", x_p_ready_o); end
    endtask

    task automatic test_single();
        wb_gnt_i = 1'b1;
        total++; if (rd_busy_o[5] !== 1'b0) begin bad++; $display("FAIL single_busy_pre: got %0b want 0", rd_busy_o[5]); end
        do_issue(5'd5, 1'b1);
        total++; if (rd_busy_o !== 32'h20 || outstanding_o !== 3'd1) begin bad++; $display("FAIL single_issue: busy=%h cnt=%0d want 20/1", rd_busy_o, outstanding_o); end
        send_resp(5'd5, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        total++; if (wb_req_o !== 1'b1 || wb_addr_o !== 5'd5 || wb_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wb: req=%0b addr=%0d data=%h want 1/5/deadbeef", wb_req_o, wb_addr_o, wb_data_o); end
        tick();
        total++; if (wb_req_o !== 1'b0 || rd_busy_o !== 32'd0 || outstanding_o !== 3'd0) begin bad++; $display("FAIL single_retire: req=%0b busy=%h cnt=%0d want 0/0/0", wb_req_o, rd_busy_o, outstanding_o); end
    endtask

    task automatic test_dualwb();
        wb_gnt_i = 1'b1;
        do_issue(5'd31, 1'b1);
        send_resp(5'd31, 64'h1111_1111_2222_2222, 1'b1, 1'b0);
        total++; if (wb_req_o !== 1'b1 || wb_addr_o !== 5'd31 || wb_data_o !== 32'h22222222) begin bad++; $display("FAIL dual_lo: req=%0b addr=%0d data=%h want 1/31/22222222", wb_req_o, wb_addr_o, wb_data_o); end
        tick();
        total++; if (wb_req_o !== 1'b0 || rd_busy_o[31] !== 1'b1) begin bad++; $display("FAIL dual_x0_skip: req=%0b busy31=%0b want 0/1", wb_req_o, rd_busy_o[31]); end
        tick();
        total++; if (rd_busy_o !== 32'd0 || outstanding_o !== 3'd0 || wb_req_o !== 1'b0) begin bad++; $display("FAIL dual_retire: busy=%h cnt=%0d req=%0b want 0/0/0", rd_busy_o, outstanding_o, wb_req_o); end
    endtask

    task automatic test_backpressure();
        wb_gnt_i = 1'b0;
        do_issue(5'd1, 1'b1); do_issue(5'd2, 1'b1); do_issue(5'd3, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        send_resp(5'd1, 64'h0000_0000_AAAA_0001, 1'b0, 1'b0);
        send_resp(5'd2, 64'h0000_0000_BBBB_0002, 1'b0, 1'b0);
        total++; if (x_p_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full: ready=%0b want 0", x_p_ready_o); end
        total++; if (wb_req_o !== 1'b1 || wb_addr_o !== 5'd1 || wb_data_o !== 32'hAAAA0001) begin bad++; $display("FAIL bp_head: req=%0b addr=%0d data=%h want 1/1/aaaa0001", wb_req_o, wb_addr_o, wb_data_o); end
        x_p_valid_i = 1'b1; x_p_rd_i = 5'd3; x_p_data_i = 64'h0000_0000_CCCC_0003;
        x_p_dualwb_i = 1'b0; x_p_error_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if (x_p_ready_o !== 1'b0 || wb_addr_o !== 5'd1 || wb_data_o !== 32'hAAAA0001) begin bad++; $display("FAIL bp_hold: ready=%0b addr=%0d data=%h want 0/1/aaaa0001", x_p_ready_o, wb_addr_o, wb_data_o); end
        wb_gnt_i = 1'b1;
        tick();
        total++; if (wb_addr_o !== 5'd2 || wb_data_o !== 32'hBBBB0002 || x_p_ready_o !== 1'b1) begin bad++; $display("FAIL bp_second: addr=%0d data=%h ready=%0b want 2/bbbb0002/1", wb_addr_o, wb_data_o, x_p_ready_o); end
        tick();
        x_p_valid_i = 1'b0;
        total++; if (wb_req_o !== 1'b1 || wb_addr_o !== 5'd3 || wb_data_o !== 32'hCCCC0003) begin bad++; $display("FAIL bp_third: req=%0b addr=%0d data=%h want 1/3/cccc0003", wb_req_o, wb_addr_o, wb_data_o); end
        tick();
        total++; if (wb_req_o !== 1'b0 || outstanding_o !== 3'd0 || rd_busy_o !== 32'd0) begin bad++; $display("FAIL bp_drained: req=%0b cnt=%0d busy=%h want 0/0/0", wb_req_o, outstanding_o, rd_busy_o); end
    endtask

    task automatic test_error();
        wb_gnt_i = 1'b1;
        do_issue(5'd7, 1'b1);
        send_resp(5'd7, 64'h0000_0000_0000_FFFF, 1'b0, 1'b1);
        total++; if (err_valid_o !== 1'b1 || err_rd_o !== 5'd7 || wb_req_o !== 1'b0) begin bad++; $display("FAIL err_pulse: v=%0b rd=%0d req=%0b want 1/7/0", err_valid_o, err_rd_o, wb_req_o); end
        tick();
        total++; if (err_valid_o !== 1'b0 || rd_busy_o !== 32'd0 || outstanding_o !== 3'd0) begin bad++; $display("FAIL err_after: v=%0b busy=%h cnt=%0d want 0/0/0", err_valid_o, rd_busy_o, outstanding_o); end
    endtask

    task automatic test_stall();
        wb_gnt_i = 1'b1;
        do_issue(5'd8, 1'b1); do_issue(5'd9, 1'b1); do_issue(5'd10, 1'b1);
        total++; if (issue_stall_o !== 1'b0) begin bad++; $display("FAIL stall_early: got %0b want 0", issue_stall_o); end
        do_issue(5'd11, 1'b1);
        total++; if (outstanding_o !== 3'd4 || issue_stall_o !== 1'b1) begin bad++; $display("FAIL stall_full: cnt=%0d stall=%0b want 4/1", outstanding_o, issue_stall_o); end
        send_resp(5'd8, 64'h0000_0000_0000_0008, 1'b0, 1'b0);
        do_issue(5'd12, 1'b1);
        total++; if (outstanding_o !== 3'd4 || issue_stall_o !== 1'b1 || rd_busy_o !== 32'h0000_1E00) begin bad++; $display("FAIL stall_swap: cnt=%0d stall=%0b busy=%h want 4/1/00001e00", outstanding_o, issue_stall_o, rd_busy_o); end
        send_resp(5'd9, 64'h9, 1'b0, 1'b0);
        send_resp(5'd10, 64'hA, 1'b0, 1'b0);
        send_resp(5'd11, 64'hB, 1'b0, 1'b0);
        send_resp(5'd12, 64'hC, 1'b0, 1'b0);
        tick();
        total++; if (outstanding_o !== 3'd0 || rd_busy_o !== 32'd0 || issue_stall_o !== 1'b0) begin bad++; $display("FAIL stall_drain: cnt=%0d busy=%h stall=%0b want 0/0/0", outstanding_o, rd_busy_o, issue_stall_o); end
    endtask

    task automatic test_reset_mid();
        do_issue(5'd4, 1'b1);
        wb_gnt_i = 1'b0;
        send_resp(5'd4, 64'hAAAA_AAAA_BBBB_BBBB, 1'b1, 1'b0);
        wb_gnt_i = 1'b1;
        tick();
        wb_gnt_i = 1'b0;
        total++; if (wb_req_o !== 1'b1 || wb_addr_o !== 5'd5 || wb_data_o !== 32'hAAAAAAAA) begin bad++; $display("FAIL mid_hi_beat: req=%0b addr=%0d data=%h want 1/5/aaaaaaaa", wb_req_o, wb_addr_o, wb_data_o); end
        rst_i = 1'b1;
        #1;
        total++; if (wb_req_o !== 1'b0 || wb_addr_o !== 5'd0 || wb_data_o !== 32'd0 || x_p_ready_o !== 1'b0) begin bad++; $display("FAIL mid_rst_out: req=%0b addr=%0d data=%h ready=%0b want 0", wb_req_o, wb_addr_o, wb_data_o, x_p_ready_o); end
        total++; if (rd_busy_o !== 32'd0 || outstanding_o !== 3'd0) begin bad++; $display("FAIL mid_rst_state: busy=%h cnt=%0d want 0/0", rd_busy_o, outstanding_o); end
        #2;
        rst_i = 1'b0;
        tick();
        total++; if (wb_req_o !== 1'b0 || x_p_ready_o !== 1'b1) begin bad++; $display("FAIL mid_post_rst: req=%0b ready=%0b want 0/1", wb_req_o, x_p_ready_o); end
        wb_gnt_i = 1'b1;
        do_issue(5'd6, 1'b1);
        send_resp(5'd6, 64'h0000_0000_1234_5678, 1'b0, 1'b0);
        total++; if (wb_req_o !== 1'b1 || wb_addr_o !== 5'd6 || wb_data_o !== 32'h12345678) begin bad++; $display("FAIL mid_next_wb: req=%0b addr=%0d data=%h want 1/6/12345678", wb_req_o, wb_addr_o, wb_data_o); end
        tick();
        total++; if (outstanding_o !== 3'd0 || rd_busy_o !== 32'd0 || wb_req_o !== 1'b0) begin bad++; $display("FAIL mid_next_retire: cnt=%0d busy=%h req=%0b want 0/0/0", outstanding_o, rd_busy_o, wb_req_o); end
    endtask

    initial begin
        rst_i = 1'b0;
        clr_issue();
        x_p_valid_i = 1'b0; x_p_rd_i = '0; x_p_data_i = '0;
        x_p_dualwb_i = 1'b0; x_p_error_i = 1'b0; wb_gnt_i = 1'b0;
        test_reset();
        test_single();
        test_dualwb();
        test_backpressure();
        test_error();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
